if_fetch_unit: RTL and testbench

Instruction-fetch stage: owns the PC, reads instruction memory and drives next_pc, instruction and flush into the IF/ID pipeline register.
Applies stall, branch/jump redirect and HALT detection.
A small run-control FSM (idle / continuous / single-step / halted) lets the debug unit start the program, step it, and detect its end.
Sits between instruction memory, the hazard/branch logic, and the IF/ID register.

---
 rtl/if_fetch_unit.sv | 100 ++++++++++
 tb/tb_if_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, applies
// stall/redirect/HALT handling and a small run-control FSM for the debug unit.
module if_fetch_unit #(
    parameter int               MSB         = 32,
    parameter int               IMEM_ADDR_W = 10,
    parameter logic [MSB-1:0]   HALT_INST   = 32'hFFFF_FFFF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_step_mode,
    input  logic                   i_step,
    input  logic                   i_stall,
    input  logic                   i_branch_taken,
    input  logic [MSB-1:0]         i_branch_target,
    input  logic                   i_jump,
    input  logic [MSB-1:0]         i_jump_target,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    input  logic [MSB-1:0]         i_imem_data,
    output logic [MSB-1:0]         o_pc,
    output logic [MSB-1:0]         o_next_pc,
    output logic [MSB-1:0]         o_inst,
    output logic                   o_flush,
    output logic                   o_halted,
    output logic [MSB-1:0]         o_fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_HALT
    } state_t;

    state_t         state_q, state_d;
    logic [MSB-1:0] pc_q, pc_d;
    logic [MSB-1:0] cnt_q, cnt_d;
    logic [MSB-1:0] pc_plus4;
    logic           adv;

    assign pc_plus4 = pc_q + MSB'(4);
    assign adv      = (state_q == ST_RUN) || ((state_q == ST_STEP) && i_step);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        o_inst    = '0;
        o_next_pc = pc_q;
        o_flush   = 1'b0;

        if (state_q == ST_IDLE && i_start) begin
            state_d = i_step_mode ? ST_STEP : ST_RUN;
        end

        if (adv) begin
            o_inst    = i_imem_data;
            o_next_pc = pc_plus4;
            cnt_d     = (&cnt_q) ? cnt_q : cnt_q + MSB'(1);

            // Branch is the older instruction, so it beats a jump; any
            // redirect beats a stall and squashes a wrong-path HALT.
            if (i_branch_taken) begin
                pc_d    = i_branch_target;
                o_flush = 1'b1;
            end else if (i_jump) begin
                pc_d    = i_jump_target;
                o_flush = 1'b1;
            end else if (i_stall) begin
                pc_d = pc_q;
            end else if (i_imem_data == HALT_INST) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the same pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_imem_addr   = pc_q[IMEM_ADDR_W+1:2];
    assign o_pc          = pc_q;
    assign o_halted      = (state_q == ST_HALT);
    assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a behavioural model pushes expected
// outputs to a scoreboard each cycle; they are popped and compared mid-cycle.
module tb_if_fetch_unit;

    localparam int          MSB  = 32;
    localparam int          AW   = 10;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STEP = 2;
    localparam int S_HALT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, step_mode, step, stall;
    logic          br, jmp;
    logic [31:0]   bt, jt;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   pc, next_pc, inst, fetch_count;
    logic          flush, halted;

    logic [31:0]   imem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    if_fetch_unit #(.MSB(MSB), .IMEM_ADDR_W(AW), .HALT_INST(HALT)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_step_mode     (step_mode),
        .i_step          (step),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (bt),
        .i_jump          (jmp),
        .i_jump_target   (jt),
        .o_imem_addr     (imem_addr),
        .i_imem_data     (imem_data),
        .o_pc            (pc),
        .o_next_pc       (next_pc),
        .o_inst          (inst),
        .o_flush         (flush),
        .o_halted        (halted),
        .o_fetch_count   (fetch_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] next_pc;
        logic        flush;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_no = 0;

    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc_no, got, exp);
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t        e;
        logic        a;
        logic [31:0] word;
        word      = imem[m_pc[AW+1:2]];
        a         = (m_state == S_RUN) || (m_state == S_STEP && step);
        e.pc      = m_pc;
        e.addr    = {22'd0, m_pc[AW+1:2]};
        e.inst    = a ? word : 32'd0;
        e.next_pc = a ? m_pc + 32'd4 : m_pc;
        e.flush   = a && (br || jmp);
        e.halted  = (m_state == S_HALT);
        e.cnt     = m_cnt;
        return e;
    endfunction

    task automatic model_clock();
        logic        a;
        logic [31:0] word;
        word = imem[m_pc[AW+1:2]];
        a    = (m_state == S_RUN) || (m_state == S_STEP && step);
        if (rst) begin
            m_state = S_IDLE;
            m_pc    = 32'd0;
            m_cnt   = 32'd0;
        end else begin
            if (m_state == S_IDLE && start)
                m_state = step_mode ? S_STEP : S_RUN;
            if (a) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (br)                 m_pc = bt;
                else if (jmp)           m_pc = jt;
                else if (stall)         m_pc = m_pc;
                else if (word == HALT)  m_state = S_HALT;
                else                    m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: push expectation, compare at the falling edge, then advance.
    task automatic cycle();
        exp_t e;
        sb.push_back(model_outputs());
        @(negedge clk);
        e = sb.pop_front();
        check("pc",      pc,                e.pc);
        check("addr",    {22'd0, imem_addr}, e.addr);
        check("inst",    inst,              e.inst);
        check("next_pc", next_pc,           e.next_pc);
        check("flush",   {31'd0, flush},    {31'd0, e.flush});
        check("halted",  {31'd0, halted},   {31'd0, e.halted});
        check("count",   fetch_count,       e.cnt);
        model_clock();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_from_reset();
        do_reset();
        start     = 1'b1;
        step_mode = 1'b0;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) imem[i] = 32'hA000_0000 + 32'(i);
        imem[0] = 32'h11;
        imem[1] = 32'h22;
        imem[2] = 32'h33;
        imem[3] = 32'h44;
        imem[4] = 32'h55;
        imem[5] = HALT;

        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; stall = 1'b0;
        br = 1'b0; jmp = 1'b0; bt = '0; jt = '0;
        @(posedge clk);
        #1;
        m_state = S_IDLE;
        m_pc    = 32'd0;
        m_cnt   = 32'd0;

        // Reset state, then continuous run with a two-cycle stall at pc 8.
        tick(2);
        rst = 1'b0;
        tick(1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        tick(2);
        stall = 1'b1;
        tick(2);
        stall = 1'b0;
        tick(2);

        // pc 16: branch + jump + stall together; branch wins.
        br = 1'b1; bt = 32'h40; jmp = 1'b1; jt = 32'h80; stall = 1'b1;
        cycle();
        br = 1'b0; jmp = 1'b0; stall = 1'b0;
        tick(3);

        // Jump alone, PC wrap-around and an unaligned target.
        jmp = 1'b1; jt = 32'h80;
        cycle();
        jmp = 1'b0;
        tick(1);
        br = 1'b1; bt = 32'hFFFF_FFFC;
        cycle();
        br = 1'b0;
        tick(2);
        jmp = 1'b1; jt = 32'h43;
        cycle();
        jmp = 1'b0;
        tick(2);

        // HALT at pc 20, first delayed by a stall; start/step then ignored.
        run_from_reset();
        tick(5);
        stall = 1'b1;
        cycle();
        stall = 1'b0;
        cycle();
        start = 1'b1; step = 1'b1; step_mode = 1'b1;
        tick(3);
        start = 1'b0; step = 1'b0; step_mode = 1'b0;
        tick(1);

        // HALT word fetched together with a jump: wrong-path, no halt.
        run_from_reset();
        tick(5);
        jmp = 1'b1; jt = 32'h100;
        cycle();
        jmp = 1'b0;
        tick(2);

        // Single-step mode, reset mid-sequence, later pulse ignored in IDLE.
        do_reset();
        start = 1'b1; step_mode = 1'b1;
        cycle();
        start = 1'b0; step_mode = 1'b0;
        tick(1);
        step = 1'b1;
        cycle();
        step = 1'b0;
        tick(1);
        rst = 1'b1; step = 1'b1;
        cycle();
        rst = 1'b0; step = 1'b0;
        tick(1);
        step = 1'b1;
        cycle();
        step = 1'b0;
        tick(1);

        // Held-high step advances every cycle; stall inside STEP holds pc.
        start = 1'b1; step_mode = 1'b1;
        cycle();
        start = 1'b0; step_mode = 1'b0;
        step = 1'b1;
        tick(2);
        stall = 1'b1;
        cycle();
        stall = 1'b0;
        tick(1);
        step = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
